text_buffer_writer: RTL and testbench

- Producer end of the character array consumed by the VGA text path.
- Accepts a byte stream (keyboard/UART/ALU result formatter) over a valid/ready handshake and maintains the N-entry ASCII array, a cursor and control-code handling.
- Its char output connects directly to the char input of controller_vga, where 8'd0 renders as a blank cell.
- Runs in the 25 MHz pixel clock domain.

---
 rtl/text_pkg.sv | 18 +
 rtl/byte_classifier.sv | 17 +
 rtl/text_buffer_writer.sv | 116 +++++++++++
 tb/tb_text_buffer_writer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared constants and state type for the text buffer writer and the VGA text path.
package text_pkg;

    localparam int DEFAULT_N_CHARS = 41;

    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_FF    = 8'h0C;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_BLANK = 8'h00;
    localparam logic [7:0] PRINT_MIN   = 8'h20;
    localparam logic [7:0] PRINT_MAX   = 8'h7E;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } wr_state_t;

endpackage

// File: rtl/byte_classifier.sv
// Decodes one input byte into the control/printable classes used by the writer.
module byte_classifier
    import text_pkg::*;
(
    input  logic [7:0] i_data,
    output logic       o_is_print,
    output logic       o_is_bs,
    output logic       o_is_cr,
    output logic       o_is_ff
);

    assign o_is_print = (i_data >= PRINT_MIN) && (i_data <= PRINT_MAX);
    assign o_is_bs    = (i_data == ASCII_BS);
    assign o_is_cr    = (i_data == ASCII_CR);
    assign o_is_ff    = (i_data == ASCII_FF);

endmodule

// File: rtl/text_buffer_writer.sv
// Byte-stream producer for the VGA character array: cursor, backspace, CR,
// form-feed clear sweep, and either wrap or scroll-left when the line fills.
module text_buffer_writer
    import text_pkg::*;
#(
    parameter  int N_CHARS = DEFAULT_N_CHARS,
    parameter  int WRAP    = 0,
    localparam int CW      = $clog2(N_CHARS + 1)
) (
    input  logic                       clock_25,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [7:0]                 in_data,
    output logic                       in_ready,
    output logic [0:N_CHARS-1][7:0]    char,
    output logic [CW-1:0]              cursor,
    output logic                       full,
    output logic                       busy
);

    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_LAST = CW'(N_CHARS - 1);
    localparam logic [CW-1:0] C_FULL = CW'(N_CHARS);

    wr_state_t                 r_state;
    wr_state_t                 w_state_next;
    logic [0:N_CHARS-1][7:0]   r_char;
    logic [CW-1:0]             r_cursor;
    logic [CW-1:0]             r_clr_idx;
    logic                      r_ready;

    logic w_is_print;
    logic w_is_bs;
    logic w_is_cr;
    logic w_is_ff;
    logic w_accept;
    logic w_clr_last;

    byte_classifier u_classifier (
        .i_data     (in_data),
        .o_is_print (w_is_print),
        .o_is_bs    (w_is_bs),
        .o_is_cr    (w_is_cr),
        .o_is_ff    (w_is_ff)
    );

    assign w_accept   = in_valid && r_ready && (r_state == IDLE);
    assign w_clr_last = (r_clr_idx == C_LAST);

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_is_ff) w_state_next = CLEAR;
            CLEAR:   if (w_clr_last)          w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // in_ready is registered so it stays low on the first cycle out of reset.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            r_char    <= '0;
            r_cursor  <= '0;
            r_clr_idx <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_ready <= (w_state_next == IDLE);
            if (r_state == CLEAR) begin
                r_char[r_clr_idx] <= ASCII_BLANK;
                if (w_clr_last) begin
                    r_clr_idx <= '0;
                    r_cursor  <= '0;
                end else begin
                    r_clr_idx <= r_clr_idx + C_ONE;
                end
            end else if (w_accept) begin
                if (w_is_print) begin
                    if (r_cursor != C_FULL) begin
                        r_char[r_cursor] <= in_data;
                        r_cursor <= ((WRAP != 0) && (r_cursor == C_LAST)) ? '0 : r_cursor + C_ONE;
                    end else if (WRAP == 0) begin
                        // Line full: shift everything left, new byte lands in the last cell.
                        for (int i = 0; i < N_CHARS - 1; i++) begin
                            r_char[i] <= r_char[i+1];
                        end
                        r_char[N_CHARS-1] <= in_data;
                    end
                end else if (w_is_bs) begin
                    if (r_cursor != '0) begin
                        r_cursor <= r_cursor - C_ONE;
                        r_char[r_cursor - C_ONE] <= ASCII_BLANK;
                    end
                end else if (w_is_cr) begin
                    r_cursor <= '0;
                end else if (w_is_ff) begin
                    r_clr_idx <= '0;
                end
            end
        end
    end

    assign char     = r_char;
    assign cursor   = r_cursor;
    assign in_ready = r_ready;
    assign busy     = (r_state == CLEAR);
    assign full     = (WRAP == 0) && (r_cursor == C_FULL);

endmodule

// File: tb/tb_text_buffer_writer.sv
// Bench for text_buffer_writer: one scroll-mode and one wrap-mode instance fed
// the same byte stream, checked every cycle against a cell-array model.
module tb_text_buffer_writer;

    localparam int N = 41;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic [0:N-1][7:0] ch [2];
    logic [5:0] cur [2];
    logic rdy [2];
    logic fl [2];
    logic bsy [2];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #20 clk = ~clk;

    text_buffer_writer #(.N_CHARS(N), .WRAP(0)) dut0 (
        .clock_25(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[0]), .char(ch[0]), .cursor(cur[0]), .full(fl[0]), .busy(bsy[0])
    );

    text_buffer_writer #(.N_CHARS(N), .WRAP(1)) dut1 (
        .clock_25(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[1]), .char(ch[1]), .cursor(cur[1]), .full(fl[1]), .busy(bsy[1])
    );

    // Model: cell contents, cursor, pending sweep cycles, readiness.
    logic [7:0] m_char [2][N];
    int m_cur [2];
    int m_clr [2];
    bit m_rdy [2];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < N; i++) m_char[k][i] = 8'h00;
                m_cur[k] = 0;
                m_clr[k] = 0;
                m_rdy[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (m_clr[k] > 0) begin
                    m_char[k][N - m_clr[k]] = 8'h00;
                    m_clr[k] = m_clr[k] - 1;
                    if (m_clr[k] == 0) begin
                        m_cur[k] = 0;
                        m_rdy[k] = 1'b1;
                    end
                end else if (!m_rdy[k]) begin
                    m_rdy[k] = 1'b1;
                end else if (in_valid) begin
                    if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                        if (m_cur[k] < N) begin
                            m_char[k][m_cur[k]] = in_data;
                            m_cur[k] = (k == 1 && m_cur[k] == N - 1) ? 0 : m_cur[k] + 1;
                        end else begin
                            for (int i = 0; i < N - 1; i++) m_char[k][i] = m_char[k][i+1];
                            m_char[k][N-1] = in_data;
                        end
                    end else if (in_data == 8'h08) begin
                        if (m_cur[k] > 0) begin
                            m_cur[k] = m_cur[k] - 1;
                            m_char[k][m_cur[k]] = 8'h00;
                        end
                    end else if (in_data == 8'h0D) begin
                        m_cur[k] = 0;
                    end else if (in_data == 8'h0C) begin
                        m_clr[k] = N;
                        m_rdy[k] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                int bad;
                bad = -1;
                for (int i = 0; i < N; i++)
                    if (bad < 0 && ch[k][i] != m_char[k][i]) bad = i;
                checks++;
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL char[%0d] inst%0d: got %0d expected %0d (t=%0t)",
                             bad, k, ch[k][bad], m_char[k][bad], $time);
                end
                chk($sformatf("cursor inst%0d", k), int'(cur[k]), m_cur[k]);
                chk($sformatf("full inst%0d", k), int'(fl[k]), (k == 0 && m_cur[k] == N) ? 1 : 0);
                chk($sformatf("busy inst%0d", k), int'(bsy[k]), (m_clr[k] > 0) ? 1 : 0);
                chk($sformatf("in_ready inst%0d", k), int'(rdy[k]), (m_rdy[k] && m_clr[k] == 0) ? 1 : 0);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] d, output int waits);
        waits = 0;
        in_valid = 1'b1;
        in_data = d;
        while (!rdy[0] && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 200) chk("send timeout", waits, 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic put(input logic [7:0] d);
        int w;
        send(d, w);
    endtask

    task automatic check_reset_vals(input string tag);
        int nz;
        nz = 0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++) if (ch[k][i] != 8'h00) nz++;
        chk({tag, " nonzero cells"}, nz, 0);
        chk({tag, " cursor"}, int'(cur[0]) + int'(cur[1]), 0);
        chk({tag, " in_ready"}, int'(rdy[0]) + int'(rdy[1]), 0);
        chk({tag, " busy"}, int'(bsy[0]) + int'(bsy[1]), 0);
        chk({tag, " full"}, int'(fl[0]) + int'(fl[1]), 0);
    endtask

    initial begin
        int w;
        #3 reset = 1'b0;
        #1 chk_en = 1'b1;
        check_reset_vals("por");
        repeat (2) @(negedge clk);
        #5 reset = 1'b1;
        repeat (3) @(negedge clk);

        // Reset mid-run, then "ABC" back-to-back.
        put(8'h41); put(8'h42);
        @(negedge clk);
        #5 reset = 1'b0;
        #1 check_reset_vals("midrun");
        @(negedge clk);
        #5 reset = 1'b1;
        repeat (2) @(negedge clk);
        put(8'h41); put(8'h42); put(8'h43);
        chk("abc char0", int'(ch[0][0]), 65);
        chk("abc char1", int'(ch[0][1]), 66);
        chk("abc char2", int'(ch[0][2]), 67);
        chk("abc char3", int'(ch[0][3]), 0);
        chk("abc cursor", int'(cur[0]), 3);

        // Backspace twice, CR, backspace at column 0.
        put(8'h08); put(8'h08);
        chk("bs cursor", int'(cur[0]), 1);
        chk("bs char1", int'(ch[0][1]), 0);
        chk("bs char2", int'(ch[0][2]), 0);
        put(8'h0D);
        chk("cr cursor", int'(cur[0]), 0);
        put(8'h08);
        chk("bs0 cursor", int'(cur[0]), 0);
        chk("bs0 char0", int'(ch[0][0]), 65);

        // Clear, then scroll test.
        put(8'h0C);
        put(8'h0D);
        for (int k = 0; k < 42; k++) begin
            put(8'h30 + 8'(k % 10));
            if (k == 40) begin
                chk("scroll full@41", int'(fl[0]), 1);
                chk("scroll cursor@41", int'(cur[0]), 41);
                chk("wrap cursor@41 (digits)", int'(cur[1]), 0);
            end
        end
        chk("scroll char0", int'(ch[0][0]), 8'h31);
        chk("scroll char40", int'(ch[0][40]), 8'h31);
        chk("scroll cursor", int'(cur[0]), 41);

        // Wrap test.
        put(8'h0C);
        for (int k = 0; k < 42; k++) begin
            put(8'h61 + 8'(k % 26));
            if (k == 40) chk("wrap cursor@41", int'(cur[1]), 0);
            chk("wrap full", int'(fl[1]), 0);
        end
        chk("wrap char0", int'(ch[1][0]), 8'h70);
        chk("wrap char1", int'(ch[1][1]), 8'h62);
        chk("wrap cursor", int'(cur[1]), 1);

        // Clear sweep with a byte held waiting.
        put(8'h0C);
        for (int k = 0; k < 10; k++) put(8'h41 + 8'(k));
        chk("fill cursor", int'(cur[0]), 10);
        put(8'h0C);
        send(8'h5A, w);
        chk("clear busy cycles", w, 41);
        chk("held byte char0", int'(ch[0][0]), 8'h5A);
        chk("held byte cursor", int'(cur[0]), 1);

        // Reset part-way through a sweep.
        put(8'h0C);
        repeat (20) @(negedge clk);
        #5 reset = 1'b0;
        #1 check_reset_vals("midclear");
        @(negedge clk);
        #5 reset = 1'b1;
        repeat (2) @(negedge clk);

        // Bytes outside every class are dropped.
        put(8'h51);
        put(8'h07);
        put(8'h7F);
        chk("ignored cursor", int'(cur[0]), 1);
        chk("ignored char0", int'(ch[0][0]), 8'h51);
        chk("ignored char1", int'(ch[0][1]), 0);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
